// File: rtl/onehot_enc_pkg.sv
// Shared constants and types for the one-hot encoder pipeline.
// IN_W is the one-hot input width, OUT_W the encoded index width.
// occ_t tracks how many results the two-entry output buffer holds.
package onehot_enc_pkg;

  localparam int IN_W  = 16;
  localparam int OUT_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/onehot_enc_core.sv
// Combinational one-hot to binary encoder.
// The index is that of the lowest set bit, or 0 for an all-zero word.
// err flags any word that is not exactly one-hot (zero or multi-hot).
module onehot_enc_core
  import onehot_enc_pkg::*;
(
  input  logic [IN_W-1:0]  onehot,
  input  logic             unused_tie,
  output logic [OUT_W-1:0] index,
  output logic             err
);

  logic [IN_W-1:0] minus_one;

  // Scan from the top down so the lowest set bit is the last to win.
  // A word is one-hot exactly when it is non-zero and clearing its lowest set bit leaves zero.
  always_comb begin
    index     = '0;
    minus_one = onehot - IN_W'(1);
    for (int i = IN_W - 1; i >= 0; i--) begin
      if (onehot[i]) begin
        index = OUT_W'(i);
      end
    end
    err = (onehot == '0) || ((onehot & minus_one) != '0) || (unused_tie & 1'b0);
  end

endmodule

// File: rtl/onehot_encoder_pipe.sv
// One-hot encoder with a valid/ready handshake on both sides.
// Words are encoded on the way in and held in a 2-entry result FIFO,
// which gives one cycle of latency and full throughput with in_ready
// taken from registered occupancy only.
// Optional feature macro: ONEHOT_ENC_ERRCNT_EN enables the saturating
// count of accepted erroneous words; without it err_count is tied to 0.
module onehot_encoder_pipe
  import onehot_enc_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_W-1:0]      onehot_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_W-1:0]     binary_out,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_count
);

  occ_t             state;
  logic [OUT_W-1:0] head_idx;
  logic             head_err;
  logic [OUT_W-1:0] tail_idx;
  logic             tail_err;
  logic [OUT_W-1:0] enc_idx;
  logic             enc_err;
  logic             push;
  logic             pop;

  onehot_enc_core u_core (
    .onehot     (onehot_in),
    .unused_tie (1'b0),
    .index      (enc_idx),
    .err        (enc_err)
  );

  assign in_ready   = (state != TWO) && !rst;
  assign out_valid  = (state != EMPTY);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign binary_out = head_idx;
  assign out_err    = head_err;

  // Occupancy FSM and result storage: the head register always drives the outputs,
  // and it is left untouched when the buffer drains so stale results stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      head_idx <= '0;
      head_err <= 1'b0;
      tail_idx <= '0;
      tail_err <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_idx <= enc_idx;
            head_err <= enc_err;
            state    <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: begin
              head_idx <= enc_idx;
              head_err <= enc_err;
            end
            2'b10: begin
              tail_idx <= enc_idx;
              tail_err <= enc_err;
              state    <= TWO;
            end
            2'b01: begin
              state <= EMPTY;
            end
            default: begin
            end
          endcase
        end
        TWO: begin
          if (pop) begin
            head_idx <= tail_idx;
            head_err <= tail_err;
            state    <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef ONEHOT_ENC_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Count accepted erroneous words, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (push && enc_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Directed self-checking bench for onehot_encoder_pipe.
// Expected err_count follows ONEHOT_ENC_ERRCNT_EN: saturating count when
// defined, constant 0 otherwise.
module tb_onehot_encoder_pipe;

  logic        clk;
  logic        rst;
  logic [15:0] onehot_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  binary_out;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_count;

  int checkCount;
  int errorCount;

  onehot_encoder_pipe #(.ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .onehot_in  (onehot_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .binary_out (binary_out),
    .out_err    (out_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err_count  (err_count)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value after n erroneous accepted words.
  function automatic logic [31:0] expCount(input int n);
`ifdef ONEHOT_ENC_ERRCNT_EN
    return (n > 255) ? 32'd255 : 32'(n);
`else
    return 32'd0 + 32'(n & 0);
`endif
  endfunction

  // Compare one observed value against its expected value and tally the result.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then settle just past the rising edge.
  task automatic applyStimulus(input logic [15:0] word, input logic valid, input logic ready);
    onehot_in = word;
    in_valid  = valid;
    out_ready = ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst       = 1'b1;
    onehot_in = 16'h0000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("in_ready_during_rst", 32'(in_ready), 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_binary_out", 32'(binary_out), 32'd0);
    checkOutput("rst_out_err", 32'(out_err), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", 32'(in_ready), 32'd1);

    applyStimulus(16'h0100, 1'b1, 1'b1);
    checkOutput("w0100_valid", 32'(out_valid), 32'd1);
    checkOutput("w0100_bin", 32'(binary_out), 32'd8);
    checkOutput("w0100_err", 32'(out_err), 32'd0);
    checkOutput("w0100_cnt", 32'(err_count), expCount(0));

    applyStimulus(16'h0000, 1'b1, 1'b1);
    checkOutput("w0000_bin", 32'(binary_out), 32'd0);
    checkOutput("w0000_err", 32'(out_err), 32'd1);
    checkOutput("w0000_cnt", 32'(err_count), expCount(1));

    applyStimulus(16'h0120, 1'b1, 1'b1);
    checkOutput("w0120_bin", 32'(binary_out), 32'd5);
    checkOutput("w0120_err", 32'(out_err), 32'd1);
    checkOutput("w0120_cnt", 32'(err_count), expCount(2));

    applyStimulus(16'h8000, 1'b0, 1'b1);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_bin_hold", 32'(binary_out), 32'd5);
    checkOutput("drain_err_hold", 32'(out_err), 32'd1);

    applyStimulus(16'h8000, 1'b1, 1'b1);
    checkOutput("w8000_bin", 32'(binary_out), 32'd15);
    checkOutput("w8000_err", 32'(out_err), 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b1);

    applyStimulus(16'h0001, 1'b1, 1'b0);
    checkOutput("bp1_ready", 32'(in_ready), 32'd1);
    checkOutput("bp1_bin", 32'(binary_out), 32'd0);
    applyStimulus(16'h0002, 1'b1, 1'b0);
    checkOutput("bp2_ready", 32'(in_ready), 32'd0);
    checkOutput("bp2_bin", 32'(binary_out), 32'd0);
    applyStimulus(16'h0004, 1'b1, 1'b0);
    checkOutput("bp3_ready", 32'(in_ready), 32'd0);
    checkOutput("bp3_bin_stable", 32'(binary_out), 32'd0);
    checkOutput("bp3_valid", 32'(out_valid), 32'd1);
    applyStimulus(16'h0004, 1'b1, 1'b1);
    checkOutput("bp_pop1_bin", 32'(binary_out), 32'd1);
    checkOutput("bp_pop1_ready", 32'(in_ready), 32'd1);
    applyStimulus(16'h0004, 1'b1, 1'b1);
    checkOutput("bp_pop2_bin", 32'(binary_out), 32'd2);
    checkOutput("bp_pop2_valid", 32'(out_valid), 32'd1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("bp_empty_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_cnt", 32'(err_count), expCount(2));

    applyStimulus(16'h0001, 1'b1, 1'b0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("two_ready", 32'(in_ready), 32'd0);
    checkOutput("two_cnt", 32'(err_count), expCount(3));
    rst       = 1'b1;
    onehot_in = 16'h0008;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_cnt", 32'(err_count), 32'd0);
    checkOutput("mid_rst_bin", 32'(binary_out), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(in_ready), 32'd1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("rst_word_dropped", 32'(out_valid), 32'd0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(16'h0000, 1'b1, 1'b1);
      if (i == 253) begin
        checkOutput("sat_254", 32'(err_count), expCount(254));
      end
      if (i == 254) begin
        checkOutput("sat_255", 32'(err_count), expCount(255));
      end
    end
    checkOutput("sat_300", 32'(err_count), expCount(300));
    checkOutput("sat_valid", 32'(out_valid), 32'd1);
    checkOutput("sat_err", 32'(out_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
